data_mem_sync: RTL
==================

// Module: data_mem_sync
// PURPOSE
//  Parametrised data memory for the mini CPU. It replaces the 16x8 combinational-read store.
//  Reads are registered (1-cycle latency) and flagged with a valid strobe.
//  An FSM zero-fills the array after reset, or on request, so programs never see X.
//  Sits between the CPU load/store stage and the register file write-back mux.
// PARAMETERS
//  DATA_W          8  word width in bits
//  ADDR_W          4  address width; DEPTH = 2**ADDR_W words
//  CLEAR_ON_RESET  1  1: zero-fill the array after reset; 0: start in IDLE, contents undefined
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  addr        in   ADDR_W  word address for read/write
//  write_en    in   1       write write_data to mem[addr] at posedge
//  read_en     in   1       read mem[addr]; data appears next cycle
//  write_data  in   DATA_W  store data
//  clear       in   1       pulse: start a zero-fill sweep of the whole array
//  read_data   out  DATA_W  registered read data; holds last value until next accepted read
//  read_valid  out  1       high for exactly 1 cycle when read_data is new
//  busy        out  1       high while sweeping; all requests are ignored
// BEHAVIOUR
//  Reset (async, rst=1):
//   - read_data=0, read_valid=0, clr_ptr=0.
//   - State=CLEAR and busy=1 if CLEAR_ON_RESET, else IDLE and busy=0.
//   - The array itself is never async-reset.
//  FSM states:
//   - IDLE: accepts requests. clear=1 -> CLEAR with clr_ptr=0, busy=1 next cycle.
//     A read/write in the same cycle as clear is still serviced.
//   - CLEAR: each cycle writes mem[clr_ptr]=0 and increments clr_ptr.
//     At clr_ptr==DEPTH-1 it writes the last word, returns to IDLE, and busy falls next cycle.
//     A sweep takes DEPTH cycles. clear asserted during CLEAR is ignored (no restart).
//  Accepted request: state==IDLE.
//   - Requests while busy: write dropped, read_valid stays 0, read_data held.
//  Write: mem[addr]<=write_data at posedge when write_en is accepted.
//  Read: read_en accepted at edge N -> read_data=mem[addr], read_valid=1 after edge N; read_valid=0 after N+1 unless another read is accepted.
//   - Back-to-back reads give one word per cycle.
//  Same-cycle read+write, same addr: write-first; read_data returns write_data.
//   - Different addresses are independent.
//  Address is always in range (DEPTH=2**ADDR_W); no wrap logic needed. clr_ptr is ADDR_W bits and wraps to 0 on exit.
//  Reset mid-sweep: async reset restarts per CLEAR_ON_RESET and clr_ptr returns to 0. Partial zeros are harmless.
//  Reset mid-read: read_valid drops immediately; the pending read is lost.
// STRUCTURE
//  Shared package cpu_mem_pkg:
//   - default DATA_W/ADDR_W constants.
//   - state typedef/localparams ST_IDLE=1'b0, ST_CLEAR=1'b1.
//  Sub-module ram_core:
//   - DEPTH x DATA_W array, single write port, async read.
//   - Write mux (clear sweep vs CPU) and all registers live in data_mem_sync.
// TESTING
//  1. Reset with CLEAR_ON_RESET=1 and DEPTH=16:
//     busy=1 for 16 cycles after rst falls, then 0; reading all 16 words gives 0x00 each.
//  2. Write 0xA5 to addr 3, then read_en addr 3 the next cycle:
//     read_data=0xA5 with read_valid=1 one cycle later; read_valid=0 the cycle after.
//  3. write_en+read_en both at addr 7 with data 0x3C (old value 0x00):
//     read_data=0x3C next cycle (write-first).
//  4. Fill addrs 0..15 with 0x10+i, pulse clear, attempt a write of 0xFF to addr 2 during busy:
//     after the sweep every word reads 0x00 and the write was dropped.
//  5. Assert rst at sweep cycle 5:
//     busy stays 1 and a full 16-cycle sweep restarts; read_data=0, read_valid=0 while rst is high.
//  6. Back-to-back reads of addrs 0,1,2 (preloaded 0x11,0x22,0x33):
//     read_valid high 3 consecutive cycles with data 0x11,0x22,0x33.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants and FSM state type for the mini CPU data memory.
package cpu_mem_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/data_mem_sync_if.sv
// CPU load/store bus to the data memory.
interface data_mem_sync_if
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);

   logic [ADDR_W-1:0] addr;
   logic              write_en;
   logic              read_en;
   logic [DATA_W-1:0] write_data;
   logic              clear;
   logic [DATA_W-1:0] read_data;
   logic              read_valid;
   logic              busy;

   modport master (
      output addr, write_en, read_en, write_data, clear,
      input  read_data, read_valid, busy
   );

   modport slave (
      input  addr, write_en, read_en, write_data, clear,
      output read_data, read_valid, busy
   );

endinterface

// File: rtl/data_mem_sync_ram_core.sv
// DEPTH x DATA_W storage array: one synchronous write port, asynchronous read.
module ram_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] read_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Array write; deliberately never reset.
   always_ff @(posedge clk) begin
      if (write_en) mem[write_addr] <= write_data;
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/data_mem_sync.sv
// Data memory with registered reads and a zero-fill sweep after reset / on request.
module data_mem_sync
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   data_mem_sync_if.slave bus
);

   localparam int unsigned       DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
   localparam state_t            RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_ptr;
   logic              accepted;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   assign accepted = (state == ST_IDLE);
   assign bus.busy = (state == ST_CLEAR);

   // Write port mux: the sweep owns the array while clearing.
   always_comb begin
      mem_we    = accepted & bus.write_en;
      mem_waddr = bus.addr;
      mem_wdata = bus.write_data;
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_ptr;
         mem_wdata = '0;
      end
   end

   ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk        (clk),
      .write_en   (mem_we),
      .write_addr (mem_waddr),
      .write_data (mem_wdata),
      .read_addr  (bus.addr),
      .read_data  (mem_rdata)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RESET_ST;
      else     state <= state_next;
   end

   // Next state: start a sweep on clear, leave after the last word.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (bus.clear)       state_next = ST_CLEAR;
         ST_CLEAR: if (clr_ptr == LAST) state_next = ST_IDLE;
         default:                       state_next = RESET_ST;
      endcase
   end

   // Sweep pointer: advances while clearing and wraps back to 0 on exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    clr_ptr <= '0;
      else if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      else                        clr_ptr <= '0;
   end

   // Registered read; a same-address write in the same cycle is forwarded (write-first).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.read_data  <= '0;
         bus.read_valid <= 1'b0;
      end else begin
         bus.read_valid <= accepted & bus.read_en;
         if (accepted && bus.read_en)
            bus.read_data <= bus.write_en ? bus.write_data : mem_rdata;
      end
   end

endmodule
